// File: rtl/comp_freq_pkg.sv
// Shared constants and types for the comparator-frequency TERO sequencer.
package comp_freq_pkg;

  localparam int unsigned NUM_BLOCKS      = 16;
  localparam int unsigned TEROS_PER_BLOCK = 8;
  localparam int unsigned NUM_STEPS       = 10;
  localparam int unsigned STEP_WEIGHT     = 128;
  localparam int unsigned CODE_W          = 11;
  localparam int unsigned CHAL_W          = 8;
  localparam int unsigned BLK_W           = 4;
  localparam int unsigned STEP_W          = $clog2(NUM_STEPS);
  localparam int unsigned OFF_W           = $clog2(TEROS_PER_BLOCK);

  typedef struct packed {
    logic [BLK_W-1:0] i;
    logic [BLK_W-1:0] j;
  } pair_t;

endpackage

// File: rtl/comp_pair_decode.sv
// Combinational challenge -> block pair (i, j) mapping, always i < j.
module comp_pair_decode
  import comp_freq_pkg::*;
(
  input  logic [CHAL_W-1:0] challenge,
  output pair_t             pair
);

  logic [2:0] r;
  logic [3:0] p;
  logic       unused_msb;

  assign r          = challenge[6:4];
  assign p          = challenge[3:0];
  assign unused_msb = challenge[7];

  // Row r owns 15-r pairs (r, r+1..15); overflowing p folds onto row 14-r.
  always_comb begin
    pair = '0;
    if ({1'b0, p} < (5'd15 - {2'b00, r})) begin
      pair.i = {1'b0, r};
      pair.j = {1'b0, r} + 4'd1 + p;
    end else begin
      pair.i = 4'd14 - {1'b0, r};
      pair.j = p;
    end
  end

endmodule

// File: rtl/comp_freq_cnt.sv
// Walks the 160 TERO/step codes of the block pair selected by the challenge.
module comp_freq_cnt
  import comp_freq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAL_W-1:0] challenge_in,
  input  logic              increment,
  output logic [CODE_W-1:0] next_TERO,
  output logic              done
);

  pair_t             pair_dec;
  pair_t             pair_q;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              half_q, half_d;
  logic              done_q, done_d;
  logic              step_wrap, offset_wrap, at_last;
  logic [BLK_W-1:0]  block;
  logic [6:0]        tero_index;

  comp_pair_decode u_decode (
    .challenge (challenge_in),
    .pair      (pair_dec)
  );

  assign step_wrap   = (step_q == STEP_W'(NUM_STEPS - 1));
  assign offset_wrap = (offset_q == OFF_W'(TEROS_PER_BLOCK - 1));
  assign at_last     = step_wrap && offset_wrap && half_q;

  always_comb begin
    step_d   = step_q;
    offset_d = offset_q;
    half_d   = half_q;
    done_d   = done_q;
    if (increment && !done_q) begin
      if (at_last) begin
        // Counters saturate on the final code; only done moves.
        done_d = 1'b1;
      end else if (step_wrap) begin
        step_d   = '0;
        offset_d = offset_q + OFF_W'(1);
        if (offset_wrap) begin
          half_d = 1'b1;
        end
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pair_q   <= pair_dec;
      step_q   <= '0;
      offset_q <= '0;
      half_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      step_q   <= step_d;
      offset_q <= offset_d;
      half_q   <= half_d;
      done_q   <= done_d;
    end
  end

  assign block      = half_q ? pair_q.j : pair_q.i;
  assign tero_index = {block, offset_q};

  // tero_index < STEP_WEIGHT, so step*128 + tero_index is a plain concatenation.
  assign next_TERO = {step_q, tero_index};
  assign done      = done_q;

endmodule

// File: tb/tb_comp_freq_cnt.sv
// Self-checking bench: directed runs plus random stimulus against a position-based model.
module tb_comp_freq_cnt;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  challenge_in;
  logic        increment;
  logic [10:0] next_TERO;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: linear position 0..159 in the sequence, plus the latched pair.
  int  m_pos  = 0;
  bit  m_done = 1'b0;
  int  m_i    = 0;
  int  m_j    = 0;

  comp_freq_cnt dut (
    .clk          (clk),
    .reset        (reset),
    .challenge_in (challenge_in),
    .increment    (increment),
    .next_TERO    (next_TERO),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input int c, output int i, output int j);
    int r, p;
    r = (c / 16) % 8;
    p = c % 16;
    if (p < 15 - r) begin
      i = r;
      j = r + 1 + p;
    end else begin
      i = 14 - r;
      j = p;
    end
  endfunction

  function automatic int ref_code();
    int step, offset, blk;
    step   = m_pos % 10;
    offset = (m_pos / 10) % 8;
    blk    = (m_pos >= 80) ? m_j : m_i;
    return step * 128 + blk * 8 + offset;
  endfunction

  // Apply inputs, take one edge, update the model, then compare away from the edge.
  task automatic do_cycle(input bit rst_n, input bit inc, input int chal);
    reset        = rst_n;
    increment    = inc;
    challenge_in = 8'(chal);
    @(posedge clk);
    if (!rst_n) begin
      ref_decode(chal, m_i, m_j);
      m_pos  = 0;
      m_done = 1'b0;
    end else if (inc && !m_done) begin
      if (m_pos == 159) m_done = 1'b1;
      else m_pos++;
    end
    #1;
    check_eq("next_TERO", int'(next_TERO), ref_code());
    check_eq("done", int'(done), int'(m_done));
  endtask

  // Reset with c, then held increment: first code, code 80, last code, then done.
  task automatic run_const(input int c, input int first, input int mid, input int last);
    do_cycle(0, 0, c);
    check_eq($sformatf("c%0d_first", c), int'(next_TERO), first);
    for (int k = 0; k < 80; k++) do_cycle(1, 1, c);
    check_eq($sformatf("c%0d_code80", c), int'(next_TERO), mid);
    for (int k = 0; k < 79; k++) do_cycle(1, 1, c);
    check_eq($sformatf("c%0d_last", c), int'(next_TERO), last);
    check_eq($sformatf("c%0d_done_pre", c), int'(done), 0);
    do_cycle(1, 1, c);
    check_eq($sformatf("c%0d_done", c), int'(done), 1);
    check_eq($sformatf("c%0d_sat", c), int'(next_TERO), last);
  endtask

  int tbl_c [5] = '{15, 30, 45, 119, 120};
  int tbl_i [5] = '{14, 13, 12, 7, 7};
  int tbl_j [5] = '{15, 14, 13, 15, 8};

  initial begin
    reset        = 1'b0;
    increment    = 1'b0;
    challenge_in = 8'd14;

    // Challenge 14: long reset, increment every other cycle, two runs.
    for (int run = 0; run < 2; run++) begin
      for (int k = 0; k < 20; k++) do_cycle(0, 0, 14);
      check_eq("c14_reset", int'(next_TERO), 0);
      for (int k = 0; k < 160; k++) begin
        do_cycle(1, 1, 14);
        do_cycle(1, 0, 14);
      end
      check_eq("c14_done", int'(done), 1);
      check_eq("c14_last", int'(next_TERO), 1279);
      for (int k = 0; k < 10; k++) do_cycle(1, 1, 14);
      check_eq("c14_stable", int'(next_TERO), 1279);
    end

    // Abort mid-run; reset together with increment must win.
    do_cycle(0, 0, 14);
    for (int k = 0; k < 37; k++) do_cycle(1, 1, 14);
    do_cycle(0, 1, 14);
    check_eq("abort_code", int'(next_TERO), 0);
    check_eq("abort_done", int'(done), 0);

    run_const(58, 24, 112, 1271);
    run_const(61, 88, 104, 1263);

    // Fixed decode points: i via the first code, j via code 80.
    for (int t = 0; t < 5; t++) begin
      do_cycle(0, 0, tbl_c[t]);
      check_eq($sformatf("dec%0d_i", tbl_c[t]), int'(next_TERO), tbl_i[t] * 8);
      for (int k = 0; k < 80; k++) do_cycle(1, 1, tbl_c[t]);
      check_eq($sformatf("dec%0d_j", tbl_c[t]), int'(next_TERO), tbl_j[t] * 8);
    end

    // Full decoder sweep, challenge scrambled after reset to show it is ignored.
    for (int c = 0; c < 128; c++) begin
      do_cycle(0, 0, c);
      for (int k = 0; k < 80; k++) do_cycle(1, 1, int'($urandom_range(255)));
    end

    // Random traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      do_cycle(($urandom_range(99) < 2) ? 1'b0 : 1'b1,
               ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
               int'($urandom_range(255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
